// File: rtl/mux_arb_nto1_reg.sv
// mux_arb_nto1_reg: N-to-1 channel selector (explicit index or round-robin) with a
// registered output stage, valid/ready handshake on every channel, and an out-of-range select flag.
module mux_arb_nto1_reg #(
    parameter int DATA_W = 32,
    parameter int CH_NUM = 4,
    parameter int SEL_W  = 2,
    parameter int MODE   = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [CH_NUM*DATA_W-1:0] data_i,
    input  logic [CH_NUM-1:0]        valid_i,
    output logic [CH_NUM-1:0]        ready_o,
    input  logic [SEL_W-1:0]         select_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [SEL_W-1:0]         ch_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic                     err_o
);
    localparam int PAD = 2 ** SEL_W;
    localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CH_NUM);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(CH_NUM - 1);
    logic                 ld;
    logic                 sel_ok;
    logic                 sel_hit;
    logic                 rr_hit;
    logic                 grant;
    logic                 err_next;
    logic [SEL_W-1:0]     ptr;
    logic [SEL_W-1:0]     rr_g;
    logic [SEL_W-1:0]     g;
    logic [SEL_W:0]       idx;
    logic [PAD-1:0]       vpad;
    logic [DATA_W-1:0]    ch_data [PAD];

    assign ld   = !valid_o || ready_i;
    assign vpad = PAD'(valid_i);

    // Channels padded to a power of two so any select_i indexes safely.
    always_comb begin
        for (int k = 0; k < PAD; k++) ch_data[k] = '0;
        for (int k = 0; k < CH_NUM; k++) ch_data[k] = data_i[k*DATA_W +: DATA_W];
    end

    assign sel_ok  = {1'b0, select_i} < CH_LIM;
    assign sel_hit = sel_ok && vpad[select_i];

    // Scan from the farthest offset down so the closest requester after ptr wins.
    always_comb begin
        rr_hit = 1'b0;
        rr_g   = '0;
        idx    = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (SEL_W + 1)'(i);
            if (idx >= CH_LIM) idx = idx - CH_LIM;
            if (vpad[idx[SEL_W-1:0]]) begin
                rr_hit = 1'b1;
                rr_g   = idx[SEL_W-1:0];
            end
        end
    end

    assign grant    = ld && ((MODE == 1) ? rr_hit : sel_hit);
    assign g        = (MODE == 1) ? rr_g : select_i;
    assign ready_o  = grant ? (CH_NUM'(1) << g) : '0;
    assign err_next = (MODE == 0) && ld && !sel_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o  <= '0;
            ch_o    <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            ptr     <= '0;
        end else begin
            err_o <= err_next;
            if (ld) begin
                valid_o <= grant;
                if (grant) begin
                    data_o <= ch_data[g];
                    ch_o   <= g;
                    if (MODE == 1) ptr <= (g == LAST) ? '0 : g + 1'b1;
                end
            end
        end
    end
endmodule
